// File: rtl/tau_to_freq_module.sv
// YIN pitch path: converts a detected lag into fixed-point frequency
// (FS << FRAC_BITS) / tau using a one-bit-per-clock restoring divider.
module tau_to_freq_module #(
  parameter int FS         = 2000,
  parameter int MAX_TAU    = 40,
  parameter int TAU_WIDTH  = 8,
  parameter int FRAC_BITS  = 4,
  parameter int FREQ_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tau_ready,
  input  logic [TAU_WIDTH-1:0]  min_tau,
  output logic [FREQ_WIDTH-1:0] freq,
  output logic                  freq_valid,
  output logic                  no_pitch,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CW = $clog2(FREQ_WIDTH);

  localparam logic [FREQ_WIDTH-1:0] DIVIDEND =
    FREQ_WIDTH'(FS << FRAC_BITS);

  localparam logic [TAU_WIDTH-1:0] TAU_MAX =
    TAU_WIDTH'(MAX_TAU);

  localparam logic [CW-1:0] CNT_TOP =
    CW'(FREQ_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t                state;
  logic                  ready_d;
  logic                  request;
  logic                  tau_bad;
  logic [FREQ_WIDTH-1:0] dividend;
  logic [TAU_WIDTH-1:0]  divisor;
  logic [TAU_WIDTH-1:0]  rem;
  logic [FREQ_WIDTH-1:0] quot;
  logic [CW-1:0]         count;

  logic [TAU_WIDTH:0]    r_shift;
  logic                  q_bit;
  logic [FREQ_WIDTH-1:0] q_next;

  assign request = tau_ready & ~ready_d;
  assign tau_bad = (min_tau == '0) || (min_tau > TAU_MAX);

  // remainder stays below divisor, so TAU_WIDTH bits hold it between steps
  always_comb begin
    r_shift = {rem, dividend[count]};
    q_bit   = (r_shift >= {1'b0, divisor});
    q_next  = quot;
    q_next[count] = q_bit;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ready_d    <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      no_pitch   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      dividend   <= '0;
      divisor    <= '0;
      rem        <= '0;
      quot       <= '0;
      count      <= '0;
    end else begin
      ready_d    <= tau_ready;
      freq_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (request) begin
            busy <= 1'b1;
            if (tau_bad) begin
              state      <= DONE;
              freq       <= '0;
              no_pitch   <= 1'b1;
              freq_valid <= 1'b1;
            end else begin
              state    <= DIV;
              dividend <= DIVIDEND;
              divisor  <= min_tau;
              rem      <= '0;
              quot     <= '0;
              count    <= CNT_TOP;
            end
          end
        end
        DIV: begin
          if (request) overrun <= 1'b1;
          if (q_bit)
            rem <= TAU_WIDTH'(r_shift - {1'b0, divisor});
          else
            rem <= r_shift[TAU_WIDTH-1:0];
          quot  <= q_next;
          count <= count - 1'b1;
          if (count == '0) begin
            state      <= DONE;
            freq       <= q_next;
            no_pitch   <= 1'b0;
            freq_valid <= 1'b1;
          end
        end
        DONE: begin
          if (request) overrun <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
